// File: rtl/sr_pulse_driver.sv
// Command-side driver for an SR flip-flop: turns a level request into a timed,
// non-overlapping set or clear pulse, tracks the expected Q and verifies feedback.
module sr_pulse_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 3,
  parameter bit          FORCE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic set_o,
  output logic clr_o,
  input  logic q_fb,
  input  logic err_clr,
  output logic q_shadow,
  output logic busy,
  output logic err
);

  localparam int unsigned CNT_W = 4;

  // Reject pulse/gap widths the 4-bit counter or the feedback synchroniser cannot honour
  if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
    $error("sr_pulse_driver: PULSE_W must be in 1..15");
  end
  if (GAP_W < 3 || GAP_W > 15) begin : g_bad_gap_w
    $error("sr_pulse_driver: GAP_W must be in 3..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lvl, lvl_next;
  logic             shadow_next, err_next;
  logic             set_next, clr_next, busy_next, ready_next;
  logic             q_meta, q_sync;

  // Two-flop synchroniser for the asynchronous Q feedback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= q_fb;
      q_sync <= q_meta;
    end
  end

  // Next-state, counter, shadow and error decode; pulse outputs follow the next state
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    lvl_next    = lvl;
    shadow_next = q_shadow;
    err_next    = err & ~err_clr;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (FORCE || (req_level != q_shadow)) begin
            state_next = ST_PULSE;
            lvl_next   = req_level;
            cnt_next   = CNT_W'(PULSE_W);
          end
        end
      end
      ST_PULSE: begin
        if (cnt == CNT_W'(1)) begin
          state_next  = ST_GAP;
          cnt_next    = CNT_W'(GAP_W);
          shadow_next = lvl;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == CNT_W'(1)) begin
          state_next = ST_IDLE;
          if (q_sync != q_shadow) begin
            err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    set_next   = (state_next == ST_PULSE) &  lvl_next;
    clr_next   = (state_next == ST_PULSE) & ~lvl_next;
    busy_next  = (state_next != ST_IDLE);
    ready_next = (state_next == ST_IDLE);
  end

  // State and registered outputs; reset drops the pulses immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lvl       <= 1'b0;
      set_o     <= 1'b0;
      clr_o     <= 1'b0;
      q_shadow  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      lvl       <= lvl_next;
      set_o     <= set_next;
      clr_o     <= clr_next;
      q_shadow  <= shadow_next;
      err       <= err_next;
      busy      <= busy_next;
      req_ready <= ready_next;
    end
  end

endmodule
